// File: rtl/deserialize_encrypt.sv
// Captures an LSB-first serial plaintext, XORs it with a latched key and holds
// the ciphertext with a level done flag until the downstream serializer finishes.
module deserialize_encrypt #(
  parameter int unsigned MSG_SIZE = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iStart,
  input  logic                iData,
  input  logic                iKey_Load,
  input  logic [MSG_SIZE-1:0] iKey,
  input  logic                iSer_Done,
  output logic [MSG_SIZE-1:0] oCiphertext,
  output logic                oEncrypt_Done,
  output logic                oBusy
);

  localparam int unsigned CntW = $clog2(MSG_SIZE) + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StShift   = 2'b01,
    StEncrypt = 2'b10,
    StHold    = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [MSG_SIZE-1:0] shift_q, shift_d;
  logic [MSG_SIZE-1:0] key_q, key_d;
  logic [MSG_SIZE-1:0] ct_q, ct_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    key_d   = key_q;
    ct_d    = ct_q;
    done_d  = done_q;

    unique case (state_q)
      StIdle: begin
        if (iKey_Load) key_d = iKey;
        if (iStart) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      StShift: begin
        // Bit position decoded by compare to keep the select width-exact.
        for (int i = 0; i < int'(MSG_SIZE); i++) begin
          if (cnt_q == CntW'(i)) shift_d[i] = iData;
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MSG_SIZE - 1)) state_d = StEncrypt;
      end
      StEncrypt: begin
        ct_d    = shift_q ^ key_q;
        done_d  = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (iSer_Done) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (iEn) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign oCiphertext   = ct_q;
  assign oEncrypt_Done = done_q;
  assign oBusy         = busy_q;

endmodule

// File: doc/deserialize_encrypt.md
Name: deserialize_encrypt

Overview:
Upstream neighbour of the ciphertext serializer. It captures an LSB-first serial plaintext message into a shift register and XORs it with a latched parallel key. It then presents the parallel ciphertext with a level "encryption done" flag. The flag is held until the downstream serializer reports completion, which closes the handshake and re-arms the block for the next message.

Parameters:
MSG_SIZE, 8, message and key width in bits (must be >= 2)

Ports:
iClk  input  1  system clock (half_clock domain, same as serializer)
iRst  input  1  asynchronous, active-high reset
iEn  input  1  stage enable; when low, all state and outputs hold
iStart  input  1  begin capture of a new message (sampled in IDLE only)
iData  input  1  serial plaintext bit, LSB first
iKey_Load  input  1  load iKey into key register (IDLE only)
iKey  input  MSG_SIZE  parallel key
iSer_Done  input  1  serializer done flag; level, releases HOLD
oCiphertext  output  MSG_SIZE  plaintext XOR key, stable while oEncrypt_Done=1
oEncrypt_Done  output  1  ciphertext valid; drives serializer iEncrypt_Done
oBusy  output  1  high in SHIFT, ENCRYPT and HOLD

Behaviour:
- Reset (iRst=1, async): state=IDLE; bit counter=0; shift reg=0; key reg=0; oCiphertext=0; oEncrypt_Done=0; oBusy=0. This takes effect immediately, from any state, including mid-message.
- All transitions and register updates occur on posedge iClk only when iEn=1. With iEn=0, nothing changes and no iData bit is sampled.
- States: IDLE, SHIFT, ENCRYPT, HOLD (2-bit encoding; no illegal-state lockup — any unused code goes to IDLE).
- IDLE:
  - iKey_Load=1 -> key reg <= iKey.
  - iStart=1 -> SHIFT, counter <= 0.
  - Both in the same cycle: the key loads and the start proceeds.
  - oCiphertext holds its last value.
- SHIFT:
  - Each enabled edge: shift[counter] <= iData; counter <= counter+1.
  - The edge that captures counter==MSG_SIZE-1 moves the block to ENCRYPT.
  - iStart and iKey_Load are ignored.
- ENCRYPT: one enabled edge. oCiphertext <= shift ^ key reg; oEncrypt_Done <= 1; -> HOLD.
- HOLD:
  - oEncrypt_Done=1 and oCiphertext stable.
  - iSer_Done=1 -> oEncrypt_Done <= 0, -> IDLE.
  - iStart and iKey_Load are ignored; a key change here does not affect the held ciphertext.
- Latency (iEn continuously 1): iStart sampled at edge E0; data bits sampled at E1..E_MSG_SIZE. ENCRYPT occupies the edge after E_MSG_SIZE, so oEncrypt_Done rises at edge E_(MSG_SIZE+1).
- Each cycle of iEn=0 during SHIFT/ENCRYPT delays completion by exactly one cycle.
- iSer_Done asserted outside HOLD has no effect.
- Counter width: clog2(MSG_SIZE)+1 bits. It never wraps within a message and is reset to 0 on each start.
- oBusy is a registered decode of state (1 when state != IDLE).

Test Plan:
- MSG_SIZE=8, iKey_Load with 0xA5, iStart, then serial bits 0,0,1,1,1,1,0,0 (0x3C) -> oCiphertext=0x99, oEncrypt_Done=1 at the 9th edge after the start edge, oBusy=1 throughout.
- Same stimulus with iEn=0 for 3 cycles after the 4th bit (iData toggled during the gap) -> oCiphertext=0x99, done 3 cycles later, toggled bits ignored.
- From HOLD (0x99): hold iSer_Done=0 for 20 cycles -> done and data stable; pulse iSer_Done -> done=0, IDLE. Then start with plaintext 0xFF -> 0x5A.
- Assert iRst asynchronously (mid-cycle) after 4 bits in SHIFT -> all outputs 0 immediately, key=0. Then start with plaintext 0x81 -> 0x81.
- In HOLD drive iStart=1, iKey_Load=1, iKey=0x00 -> oCiphertext unchanged, no capture. After release, the next message still uses key 0xA5.
- In IDLE: iStart and iKey_Load=1 with iKey=0x0F on the same edge, plaintext 0xF0 -> 0xFF.
